// File: rtl/pdfd_pkg.sv
// Shared PAM5 symbol types and helpers for the LaPDFD output path.
package pdfd_pkg;

    typedef logic signed [2:0] pam5_sym_t;
    typedef pam5_sym_t [3:0]   pam5_word_t;

    localparam int          PAM5_MIN  = -2;
    localparam int          PAM5_MAX  = 2;
    localparam int unsigned NUM_LANES = 4;

    // True when every lane holds a legal PAM5 level (-2..+2).
    function automatic logic pam5_word_valid(input pam5_word_t w);
        logic      ok;
        pam5_sym_t s;
        ok = 1'b1;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            s = w[i];
            if (int'(s) < PAM5_MIN || int'(s) > PAM5_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/pdfd_sym_fifo_mem.sv
// DEPTH x 12 register array: one synchronous write port, one asynchronous read port.
module pdfd_sym_fifo_mem #(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [11:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [11:0]   rd_data
);

    logic [11:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pdfd_sym_fifo.sv
// Elastic buffer after the LaPDFD decoder with sticky overflow flag.
// Optional invalid-symbol word counter enabled by macro PDFD_SYM_ERRCNT_EN.
module pdfd_sym_fifo
    import pdfd_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [11:0]   io_rxData,
    input  logic          io_rxValid,
    input  logic          io_flush,
    output logic [11:0]   io_deqData,
    output logic          io_deqValid,
    input  logic          io_deqReady,
    output logic [CW-1:0] io_count,
    output logic          io_overflow,
    input  logic          io_clearOverflow,
    output logic [15:0]   io_errCount
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, non_empty, deq, wr_en, ovf_event;
    logic [11:0]   rd_data;

    always_comb begin
        non_empty = (count_q != '0);
        full      = (count_q == CW'(DEPTH));
        deq       = non_empty & io_deqReady;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        wr_en     = io_rxValid & (~full | deq) & ~io_flush;
        ovf_event = io_rxValid & full & ~deq & ~io_flush;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = ovf_event | (overflow_q & ~io_clearOverflow);

        if (io_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (wr_en && !deq) begin
                count_d = count_q + CW'(1);
            end else if (!wr_en && deq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    pdfd_sym_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (io_rxData),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign io_deqValid = non_empty;
    assign io_deqData  = non_empty ? rd_data : '0;
    assign io_count    = count_q;
    assign io_overflow = overflow_q;

`ifdef PDFD_SYM_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Counted on arrival, so dropped words are still included.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (io_flush) begin
            err_cnt_d = '0;
        end else if (io_rxValid && !pam5_word_valid(pam5_word_t'(io_rxData))
                     && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign io_errCount = err_cnt_q;
`else
    assign io_errCount = '0;
`endif

endmodule

// File: tb/tb_pdfd_sym_fifo.sv
// Directed-vector bench for pdfd_sym_fifo; error-counter checks follow PDFD_SYM_ERRCNT_EN.
module tb_pdfd_sym_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] io_rxData;
    logic        io_rxValid;
    logic        io_flush;
    logic [11:0] io_deqData;
    logic        io_deqValid;
    logic        io_deqReady;
    logic [3:0]  io_count;
    logic        io_overflow;
    logic        io_clearOverflow;
    logic [15:0] io_errCount;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    pdfd_sym_fifo #(
        .DEPTH (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .io_rxData        (io_rxData),
        .io_rxValid       (io_rxValid),
        .io_flush         (io_flush),
        .io_deqData       (io_deqData),
        .io_deqValid      (io_deqValid),
        .io_deqReady      (io_deqReady),
        .io_count         (io_count),
        .io_overflow      (io_overflow),
        .io_clearOverflow (io_clearOverflow),
        .io_errCount      (io_errCount)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [11:0] d);
        io_rxValid = 1'b1;
        io_rxData  = d;
        tick();
        io_rxValid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; io_rxData = '0; io_rxValid = 1'b0; io_flush = 1'b0;
        io_deqReady = 1'b0; io_clearOverflow = 1'b0;

        // 1. reset state
        repeat (4) tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", 32'(io_deqValid), 32'd0);
        chk("rst_count", 32'(io_count), 32'd0);
        chk("rst_data",  32'(io_deqData), 32'h000);
        chk("rst_ovf",   32'(io_overflow), 32'd0);
        chk("rst_err",   32'(io_errCount), 32'd0);

        // 2. fill 1..8 then drain in order
        for (int i = 1; i <= 8; i++) begin
            push(12'(i));
            chk("fill_count", 32'(io_count), 32'(i));
        end
        chk("fill_head", 32'(io_deqData), 32'h001);
        chk("fill_valid", 32'(io_deqValid), 32'd1);
        io_deqReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 32'(io_deqData), 32'(i));
            tick();
        end
        io_deqReady = 1'b0;
        chk("drain_count", 32'(io_count), 32'd0);
        chk("drain_valid", 32'(io_deqValid), 32'd0);
        chk("drain_data0", 32'(io_deqData), 32'h000);

        // 3. overflow on full, clear, and event-wins-over-clear
        for (int i = 0; i < 8; i++) push(12'h010 + 12'(i));
        push(12'h0AA);
        chk("ovf_set",   32'(io_overflow), 32'd1);
        chk("ovf_count", 32'(io_count), 32'd8);
        chk("ovf_head",  32'(io_deqData), 32'h010);
        io_clearOverflow = 1'b1;
        tick();
        chk("ovf_clr", 32'(io_overflow), 32'd0);
        push(12'h0AB);
        chk("ovf_wins", 32'(io_overflow), 32'd1);
        tick();
        io_clearOverflow = 1'b0;
        chk("ovf_clr2", 32'(io_overflow), 32'd0);

        // 4. full with simultaneous enq and deq
        io_deqReady = 1'b1;
        push(12'h0BB);
        io_deqReady = 1'b0;
        chk("fd_count", 32'(io_count), 32'd8);
        chk("fd_ovf",   32'(io_overflow), 32'd0);
        chk("fd_head",  32'(io_deqData), 32'h011);
        io_deqReady = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("fd_drain", 32'(io_deqData), 32'h010 + 32'(i));
            tick();
        end
        chk("fd_tail", 32'(io_deqData), 32'h0BB);
        tick();
        chk("fd_empty", 32'(io_deqValid), 32'd0);
        io_deqReady = 1'b0;

        // 5. flush: overrides enq, keeps overflow, no overflow from a full flush
        for (int i = 0; i < 8; i++) push(12'h030 + 12'(i));
        push(12'h0AA);
        chk("fl_ovf_pre", 32'(io_overflow), 32'd1);
        io_flush = 1'b1; tick(); io_flush = 1'b0;
        for (int i = 1; i <= 3; i++) push(12'h020 + 12'(i));
        chk("fl_count3", 32'(io_count), 32'd3);
        io_flush = 1'b1; io_rxValid = 1'b1; io_rxData = 12'h0CC; io_deqReady = 1'b1;
        tick();
        io_flush = 1'b0; io_rxValid = 1'b0; io_deqReady = 1'b0;
        chk("fl_count", 32'(io_count), 32'd0);
        chk("fl_valid", 32'(io_deqValid), 32'd0);
        chk("fl_data",  32'(io_deqData), 32'h000);
        chk("fl_ovf",   32'(io_overflow), 32'd1);
        io_clearOverflow = 1'b1; tick(); io_clearOverflow = 1'b0;
        for (int i = 0; i < 8; i++) push(12'h040 + 12'(i));
        io_flush = 1'b1; io_rxValid = 1'b1; io_rxData = 12'h0DD;
        tick();
        io_flush = 1'b0; io_rxValid = 1'b0;
        chk("flf_ovf",   32'(io_overflow), 32'd0);
        chk("flf_count", 32'(io_count), 32'd0);
        push(12'h055);
        chk("flp_count", 32'(io_count), 32'd1);
        chk("flp_head",  32'(io_deqData), 32'h055);

        // 6. invalid-symbol word counter
        io_flush = 1'b1; tick(); io_flush = 1'b0;
        chk("err_flush", 32'(io_errCount), 32'd0);
        push(12'h003);
        push(12'h800);
        push(12'hFFF);
        chk("err_head", 32'(io_deqData), 32'h003);
        chk("err_cnt3", 32'(io_count), 32'd3);
`ifdef PDFD_SYM_ERRCNT_EN
        chk("err_two", 32'(io_errCount), 32'd2);
        io_rxValid = 1'b1; io_rxData = 12'h003;
        for (int i = 0; i < 65532; i++) begin
            @(posedge clock);
        end
        #1;
        chk("err_fffe", 32'(io_errCount), 32'h0000FFFE);
        tick();
        chk("err_ffff", 32'(io_errCount), 32'h0000FFFF);
        repeat (3) tick();
        io_rxValid = 1'b0;
        chk("err_sat", 32'(io_errCount), 32'h0000FFFF);
        io_flush = 1'b1; tick(); io_flush = 1'b0;
        chk("err_clr", 32'(io_errCount), 32'd0);
`else
        chk("err_off", 32'(io_errCount), 32'd0);
`endif

        // reset beats a concurrent flush and enqueue
        io_flush = 1'b1; tick(); io_flush = 1'b0;
        push(12'h066);
        push(12'h0AA);
        reset = 1'b1; io_flush = 1'b1; io_rxValid = 1'b1; io_rxData = 12'h077;
        tick();
        reset = 1'b0; io_flush = 1'b0; io_rxValid = 1'b0;
        chk("rst2_count", 32'(io_count), 32'd0);
        chk("rst2_valid", 32'(io_deqValid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
